fft_iter_ctrl_unit: RTL and testbench
=====================================

// Module: fft_iter_ctrl_unit
// PURPOSE
//  Sequencer for the iterative radix-2 DIT FFT. Walks AWL layers of 2^(AWL-1) butterflies each.
//  Drives butterfly read/write strobes and indices. Drives W_EN / LAY_EN / W_CLR of w_address_gen_unit
//  (twiddle address generator, directly downstream).
//  Inserts a drain gap of BF_LAT cycles after every layer so in-place writes land before the next layer reads.
// PARAMETERS
//  AWL     5  transform size 2^AWL points; AWL layers, 2^(AWL-1) butterflies per layer (AWL>=2)
//  BF_LAT  3  butterfly read-to-write pipeline latency in cycles (BF_LAT>=1)
// PORTS
//  CLK      in   1           clock, all logic on rising edge
//  RST      in   1           synchronous, active-high reset
//  START    in   1           start request; sampled only in IDLE
//  RD_EN    out  1           butterfly operand read strobe, one per butterfly
//  WR_EN    out  1           butterfly result write strobe = RD_EN delayed BF_LAT cycles
//  BF_IDX   out  AWL-1       butterfly index within current layer (valid when RD_EN=1)
//  LAY_IDX  out  LWL         current layer index, LWL=clog2(AWL)
//  W_EN     out  1           to w_address_gen_unit.EN; equals RD_EN
//  LAY_EN   out  1           to w_address_gen_unit.LAY_EN; 1 on last butterfly of each layer
//  W_CLR    out  1           1-cycle pulse on START accept; top ORs it into w_address_gen_unit.RST
//  BUSY     out  1           1 in every state except IDLE
//  DONE     out  1           1-cycle pulse, transform complete
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; BF_IDX=0, LAY_IDX=0; WR delay line cleared. RST mid-transform aborts immediately to these values.
//  FSM states: IDLE, RUN, DRAIN, FINISH (registered state, registered outputs)
//  IDLE:   START=1 -> W_CLR=1 this cycle, BF_IDX<=0, LAY_IDX<=0, next=RUN. START=0 -> stay.
//  RUN:    RD_EN=W_EN=1 every cycle; BF_IDX increments by 1.
//          When BF_IDX==2^(AWL-1)-1: LAY_EN=1 same cycle, drain counter<=BF_LAT-1, next=DRAIN.
//  DRAIN:  RD_EN=W_EN=0; counter decrements; lasts exactly BF_LAT cycles.
//          At counter==0: LAY_IDX==AWL-1 -> FINISH. Otherwise LAY_IDX++, BF_IDX<=0, next=RUN.
//  FINISH: DONE=1 for one cycle, BUSY=1, next=IDLE.
//  WR_EN:  RD_EN shifted BF_LAT stages. Last WR_EN of a layer falls in the last DRAIN cycle, never overlapping the next RD_EN.
//  Timing: START accepted at cycle t -> first RD_EN at t+1; DONE at t+1+AWL*(2^(AWL-1)+BF_LAT).
//  Twiddle alignment: W_ADDR is valid during each RD_EN cycle. W_EN advances it for the next butterfly.
//          LAY_EN on the last butterfly rotates the stride for the next layer.
//  START while BUSY is ignored. START in the same cycle as DONE is ignored (FSM not yet in IDLE).
//  BF_IDX wraps only via explicit reset to 0; no modular overflow path.
// CONFIGURATION
//  Macro FFT_CTRL_HOLD_EN:
//   defined: adds input HOLD (1 bit). While HOLD=1 in RUN/DRAIN, state, counters, indices and WR delay line are frozen.
//            RD_EN, W_EN, LAY_EN and WR_EN are forced 0. The butterfly datapath is stalled by the same HOLD.
//            HOLD in IDLE/FINISH has no effect.
//   undefined: no HOLD port; sequencing is free-running as above.
// STRUCTURE
//  fft_iter_pkg: state encoding localparams (ST_IDLE..ST_FINISH) and clog2 function for LWL.
//  Sub-module valid_delay_line #(DEPTH=BF_LAT): 1-bit shift register with sync clear and enable; produces WR_EN.
//  Counters and FSM live in fft_iter_ctrl_unit. No other hierarchy.
// TESTING
//  1 Reset then idle, AWL=5 BF_LAT=3: all outputs 0 for 20 cycles with START=0.
//  2 Full run: START at t -> W_CLR at t; RD_EN high t+1..t+16; LAY_EN at t+16; 80 RD_EN total.
//    LAY_IDX steps 0..4; DONE only at t+96; 80 WR_EN pulses, each 3 cycles after its RD_EN.
//  3 With w_address_gen_unit attached: W_ADDR sequence per layer matches the DIT twiddle reference model for all 5 layers.
//  4 START pulsed at t+10 and t+95 during a run: ignored; DONE still at t+96, single transform only.
//  5 RST asserted at t+40: next cycle IDLE, BUSY=0, WR_EN=0, indices 0. New START runs a clean full transform.
//  6 FFT_CTRL_HOLD_EN: HOLD=1 for 7 cycles mid-layer 2 and 2 cycles in DRAIN -> no strobes while held.
//    Index sequence unchanged; DONE delayed by exactly 9 cycles.

Source files
------------

// File: rtl/fft_iter_pkg.sv
// Shared definitions for the iterative radix-2 DIT FFT sequencer:
// state encoding and a constant-foldable ceil(log2) helper.
package fft_iter_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_RUN    = ST_RUN,
    S_DRAIN  = ST_DRAIN,
    S_FINISH = ST_FINISH
  } state_t;

  // Smallest r with 2^r >= value; used for index and counter widths.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/valid_delay_line.sv
// 1-bit valid delay line: dout follows din DEPTH enabled clocks later.
// Synchronous clear empties every stage; en=0 freezes the whole line.
module valid_delay_line #(
  parameter int DEPTH = 3
) (
  input  logic clk,
  input  logic clr,
  input  logic en,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] stages;

  // Shift din into the bottom stage; the top stage is the delayed output.
  always_ff @(posedge clk) begin
    if (clr) begin
      stages <= '0;
    end else if (en) begin
      stages <= (stages << 1) | DEPTH'(din);
    end
  end

  assign dout = stages[DEPTH-1];

endmodule

// File: rtl/fft_iter_ctrl_unit.sv
// Sequencer for an iterative radix-2 DIT FFT. Walks AWL layers of
// 2^(AWL-1) butterflies, inserting a BF_LAT-cycle drain after every layer
// so in-place writes retire before the next layer starts reading.
// Also steers the twiddle address generator (W_EN / LAY_EN / W_CLR).
// Optional feature macro: FFT_CTRL_HOLD_EN adds a HOLD input that freezes
// the sequencer in RUN/DRAIN and masks all strobes while asserted.
module fft_iter_ctrl_unit
  import fft_iter_pkg::*;
#(
  parameter int AWL    = 5,
  parameter int BF_LAT = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
`ifdef FFT_CTRL_HOLD_EN
  input  logic                       hold,
`endif
  output logic                       rd_en,
  output logic                       wr_en,
  output logic [AWL-2:0]             bf_idx,
  output logic [clog2(AWL)-1:0]      lay_idx,
  output logic                       w_en,
  output logic                       lay_en,
  output logic                       w_clr,
  output logic                       busy,
  output logic                       done
);

  localparam int BW = AWL - 1;
  localparam int LW = clog2(AWL);
  localparam int CW = (BF_LAT > 1) ? clog2(BF_LAT) : 1;
  localparam logic [BW-1:0] BF_LAST  = {BW{1'b1}};
  localparam logic [LW-1:0] LAY_LAST = LW'(AWL - 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(BF_LAT - 1);

  state_t        state;
  logic [BW-1:0] bf_r;
  logic [LW-1:0] lay_r;
  logic [CW-1:0] cnt_r;
  logic          rd_r;
  logic          lay_en_r;
  logic          busy_r;
  logic          done_r;
  logic          stall;
  logic          adv;
  logic          wr_dly;

  // A stall only means something while butterflies are in flight.
`ifdef FFT_CTRL_HOLD_EN
  assign stall = hold & ((state == S_RUN) | (state == S_DRAIN));
`else
  assign stall = 1'b0;
`endif
  assign adv = ~stall;

  // Main sequencer: state, indices, drain counter and registered strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      bf_r     <= '0;
      lay_r    <= '0;
      cnt_r    <= '0;
      rd_r     <= 1'b0;
      lay_en_r <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else if (adv) begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_RUN;
            bf_r     <= '0;
            lay_r    <= '0;
            rd_r     <= 1'b1;
            lay_en_r <= 1'b0;
            busy_r   <= 1'b1;
          end
        end
        S_RUN: begin
          if (bf_r == BF_LAST) begin
            // Last butterfly issued this cycle; let the pipeline empty.
            state    <= S_DRAIN;
            cnt_r    <= CNT_INIT;
            rd_r     <= 1'b0;
            lay_en_r <= 1'b0;
          end else begin
            bf_r     <= bf_r + BW'(1);
            lay_en_r <= ((bf_r + BW'(1)) == BF_LAST);
          end
        end
        S_DRAIN: begin
          if (cnt_r == '0) begin
            if (lay_r == LAY_LAST) begin
              state  <= S_FINISH;
              done_r <= 1'b1;
            end else begin
              state    <= S_RUN;
              lay_r    <= lay_r + LW'(1);
              bf_r     <= '0;
              rd_r     <= 1'b1;
              lay_en_r <= 1'b0;
            end
          end else begin
            cnt_r <= cnt_r - CW'(1);
          end
        end
        S_FINISH: begin
          state  <= S_IDLE;
          done_r <= 1'b0;
          busy_r <= 1'b0;
        end
        default: begin
          state    <= S_IDLE;
          bf_r     <= '0;
          lay_r    <= '0;
          cnt_r    <= '0;
          rd_r     <= 1'b0;
          lay_en_r <= 1'b0;
          busy_r   <= 1'b0;
          done_r   <= 1'b0;
        end
      endcase
    end
  end

  // Write strobe is the read strobe delayed by the butterfly latency.
  valid_delay_line #(
    .DEPTH (BF_LAT)
  ) u_wr_dly (
    .clk  (clk),
    .clr  (rst),
    .en   (adv),
    .din  (rd_r),
    .dout (wr_dly)
  );

  // W_CLR must clear the twiddle generator in the accept cycle itself so
  // its address is 0 when the first butterfly reads; hence decoded from
  // the registered state and the live START, masked during reset.
  assign w_clr   = (state == S_IDLE) & start & ~rst;
  assign rd_en   = rd_r & adv;
  assign w_en    = rd_r & adv;
  assign lay_en  = lay_en_r & adv;
  assign wr_en   = wr_dly & adv;
  assign bf_idx  = bf_r;
  assign lay_idx = lay_r;
  assign busy    = busy_r;
  assign done    = done_r;

endmodule

// File: tb/tb_fft_iter_ctrl_unit.sv
// Self-checking bench for fft_iter_ctrl_unit (AWL=5, BF_LAT=3).
module tb_fft_iter_ctrl_unit;

  localparam int AWL    = 5;
  localparam int BF_LAT = 3;
  localparam int NBF    = 16;
  localparam int PER    = NBF + BF_LAT;
  localparam int TDONE  = 1 + AWL * PER;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
`ifdef FFT_CTRL_HOLD_EN
  logic       hold;
`endif
  logic       rd_en, wr_en, w_en, lay_en, w_clr, busy, done;
  logic [3:0] bf_idx;
  logic [2:0] lay_idx;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    int cyc;
    int lay;
    int bf;
  } rd_exp_t;

  rd_exp_t rd_q[$];
  int      wr_q[$];
  int      done_q[$];
  rd_exp_t mon_e;
  int      mon_c;

  typedef struct {
    int   k;
    logic rd, wr, le, busy, done, wclr;
    int   lay;
  } vec_t;

  vec_t tbl[13];

  fft_iter_ctrl_unit #(.AWL(AWL), .BF_LAT(BF_LAT)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
`ifdef FFT_CTRL_HOLD_EN
    .hold    (hold),
`endif
    .rd_en   (rd_en),
    .wr_en   (wr_en),
    .bf_idx  (bf_idx),
    .lay_idx (lay_idx),
    .w_en    (w_en),
    .lay_en  (lay_en),
    .w_clr   (w_clr),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  // Cycle index: after posedge n, cyc == n.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue the expected butterfly/write/done events of one transform.
  task automatic push_run(input int t, input bit timed, input int done_cyc);
    for (int l = 0; l < AWL; l++) begin
      for (int b = 0; b < NBF; b++) begin
        rd_q.push_back('{timed ? t + 1 + l * PER + b : -1, l, b});
        wr_q.push_back(timed ? t + 1 + l * PER + b + BF_LAT : -1);
      end
    end
    done_q.push_back(done_cyc);
  endtask

  // Scoreboard monitor: pops expectations as the DUT emits strobes.
  always @(posedge clk) begin
    #3;
    if (rd_en === 1'b1) begin
      if (rd_q.size() == 0) begin
        check("rd_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = rd_q.pop_front();
        if (mon_e.cyc >= 0) check("rd_cycle", cyc, mon_e.cyc);
        check("rd_lay_idx", 32'(lay_idx), mon_e.lay);
        check("rd_bf_idx", 32'(bf_idx), mon_e.bf);
        check("rd_lay_en", 32'(lay_en), 32'(mon_e.bf == NBF - 1));
        check("rd_w_en", 32'(w_en), 32'd1);
      end
    end else if ((w_en === 1'b1) || (lay_en === 1'b1)) begin
      check("strobe_without_rd", {30'd0, w_en, lay_en}, 32'd0);
    end
    if (wr_en === 1'b1) begin
      if (wr_q.size() == 0) begin
        check("wr_unexpected", 32'd1, 32'd0);
      end else begin
        mon_c = wr_q.pop_front();
        if (mon_c >= 0) check("wr_cycle", cyc, mon_c);
      end
    end
    if (done === 1'b1) begin
      if (done_q.size() == 0) begin
        check("done_unexpected", 32'd1, 32'd0);
      end else begin
        mon_c = done_q.pop_front();
        check("done_cycle", cyc, mon_c);
      end
    end
`ifdef FFT_CTRL_HOLD_EN
    if (hold && (rd_en || wr_en || lay_en)) check("strobe_in_hold", 32'd1, 32'd0);
`endif
  end

  task automatic check_queues_empty(input string tag);
    check({tag, "_rd_left"}, rd_q.size(), 32'd0);
    check({tag, "_wr_left"}, wr_q.size(), 32'd0);
    check({tag, "_done_left"}, done_q.size(), 32'd0);
  endtask

  // One full transform, checking table checkpoints; optionally pulses
  // START while busy and in the DONE cycle, which must be ignored.
  task automatic run_full(input bit extra_starts);
    int t;
    int vi;
    tick();
    t = cyc;
    start = 1'b1;
    push_run(t, 1'b1, t + TDONE);
    vi = 0;
    for (int k = 0; k <= TDONE + 1; k++) begin
      if (k > 0) begin
        tick();
        start = extra_starts && ((k == 10) || (k == 95) || (k == 96));
      end
      #1;
      if ((vi < 13) && (tbl[vi].k == k)) begin
        check($sformatf("k%0d_rd", k), 32'(rd_en), 32'(tbl[vi].rd));
        check($sformatf("k%0d_wr", k), 32'(wr_en), 32'(tbl[vi].wr));
        check($sformatf("k%0d_lay_en", k), 32'(lay_en), 32'(tbl[vi].le));
        check($sformatf("k%0d_busy", k), 32'(busy), 32'(tbl[vi].busy));
        check($sformatf("k%0d_done", k), 32'(done), 32'(tbl[vi].done));
        check($sformatf("k%0d_w_clr", k), 32'(w_clr), 32'(tbl[vi].wclr));
        if (tbl[vi].lay >= 0) check($sformatf("k%0d_lay_idx", k), 32'(lay_idx), tbl[vi].lay);
        vi++;
      end
    end
    start = 1'b0;
    check_queues_empty("run");
    for (int k = 0; k < 5; k++) tick();
    check("idle_after_run_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    tbl[0]  = '{0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1};
    tbl[1]  = '{1,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0};
    tbl[2]  = '{4,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0};
    tbl[3]  = '{16, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    tbl[4]  = '{17, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0};
    tbl[5]  = '{19, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0};
    tbl[6]  = '{20, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1};
    tbl[7]  = '{39, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2};
    tbl[8]  = '{58, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3};
    tbl[9]  = '{77, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4};
    tbl[10] = '{92, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4};
    tbl[11] = '{96, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4};
    tbl[12] = '{97, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1};

    rst   = 1'b1;
    start = 1'b0;
`ifdef FFT_CTRL_HOLD_EN
    hold  = 1'b0;
`endif
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b0;

    // Idle after reset: every output stays low.
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_outputs",
            {21'd0, rd_en, wr_en, w_en, lay_en, w_clr, busy, done, bf_idx},
            32'd0);
      check("idle_lay_idx", 32'(lay_idx), 32'd0);
    end

    // Plain transform, then one with ignored START pulses.
    run_full(1'b0);
    run_full(1'b1);

    // Abort with reset at t+40, then a clean transform.
    begin
      int t;
      tick();
      t = cyc;
      start = 1'b1;
      push_run(t, 1'b1, t + TDONE);
      for (int k = 1; k <= 40; k++) begin
        tick();
        start = 1'b0;
        rst = (k == 40);
      end
      tick();
      rd_q.delete();
      wr_q.delete();
      done_q.delete();
      rst = 1'b0;
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_strobes", {26'd0, rd_en, wr_en, w_en, lay_en, done, w_clr}, 32'd0);
      check("abort_bf_idx", 32'(bf_idx), 32'd0);
      check("abort_lay_idx", 32'(lay_idx), 32'd0);
      for (int k = 0; k < 4; k++) begin
        tick();
        check("abort_wr_flushed", 32'(wr_en), 32'd0);
      end
      run_full(1'b0);
    end

`ifdef FFT_CTRL_HOLD_EN
    // Hold 7 cycles mid layer 2 and 2 cycles in layer 3 drain.
    begin
      int t;
      tick();
      t = cyc;
      start = 1'b1;
      push_run(t, 1'b0, t + TDONE + 9);
      for (int k = 1; k <= TDONE + 11; k++) begin
        tick();
        start = 1'b0;
        hold = ((k >= 45) && (k <= 51)) || (k == 82) || (k == 83);
      end
      hold = 1'b0;
      check_queues_empty("hold");
    end
`endif

    for (int k = 0; k < 3; k++) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
